// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the multiply/divide sequencer:
//   - R-type funct codes it decodes (MULT, MULTU, DIV, DIVU, MTHI, MTLO)
//   - the sequencer state encoding
//   - a small decode helper for the four iterative operations
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } muldiv_state_t;

  // True for the four operations that go through the iterative datapath.
  function automatic logic is_iterative(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration of the multiply/divide datapath.
//   multiply (is_div=0): acc  = 2*WIDTH product accumulator
//                        q    = remaining multiplier bits (shifted right)
//                        opnd = multiplicand, shifted left each step
//   divide   (is_div=1): acc  = partial remainder in the low WIDTH bits
//                        q    = dividend bits shifting out the top,
//                               quotient bits shifting in the bottom
//                        opnd = divisor in the low WIDTH bits
// Ports:
//   is_div     in   1          selects trial-subtract (1) or add-shift (0)
//   acc/q/opnd in   see above  current datapath state
//   *_next     out  see above  datapath state after this iteration
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     q,
  input  logic [2*WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic [WIDTH-1:0]     q_next,
  output logic [2*WIDTH-1:0]   opnd_next
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Remainder shifted left with the next dividend bit brought in. The
    // remainder is always below the divisor, so trial < 2*divisor and the
    // true difference fits in WIDTH bits whenever trial >= divisor.
    trial     = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff      = trial[WIDTH-1:0] - opnd[WIDTH-1:0];
    acc_next  = acc;
    q_next    = q;
    opnd_next = opnd;
    if (is_div) begin
      if (trial >= {1'b0, opnd[WIDTH-1:0]}) begin
        acc_next = {{WIDTH{1'b0}}, diff};
        q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
        q_next   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next  = q[0] ? (acc + opnd) : acc;
      q_next    = q >> 1;
      opnd_next = opnd << 1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns HI/LO.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
// operand magnitudes; signs are applied in a final FIX cycle.
// Ports:
//   clk      in   1      clock, rising edge
//   reset_n  in   1      asynchronous active-low reset
//   start    in   1      request strobe, only honoured while idle
//   fncode   in   6      R-type funct code
//   op_a     in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO data)
//   op_b     in   WIDTH  rt value (multiplier / divisor)
//   busy     out  1      sequencer not idle
//   done     out  1      one-cycle pulse, HI/LO freshly written
//   hi, lo   out  WIDTH  HI/LO registers
// Build option:
//   MULDIV_EARLY_OUT_EN  multiplies finish as soon as the remaining
//                        multiplier bits are all zero.
// -----------------------------------------------------------------------------
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t      state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [2*WIDTH-1:0] opnd_reg, opnd_next;
  logic               is_div_reg, is_div_next;
  logic               neg_res_reg, neg_res_next;   // product / quotient negative
  logic               neg_rem_reg, neg_rem_next;   // remainder negative
  logic               div_zero_reg, div_zero_next;
  logic [WIDTH-1:0]   a_raw_reg, a_raw_next;       // unmodified dividend for /0
  logic [WIDTH-1:0]   hi_reg, hi_next;
  logic [WIDTH-1:0]   lo_reg, lo_next;
  logic               done_reg, done_next;

  // Start-time operand decode.
  logic               op_signed, op_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign op_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
  assign op_div    = (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
  assign a_neg     = op_signed & op_a[WIDTH-1];
  assign b_neg     = op_signed & op_b[WIDTH-1];
  assign a_mag     = a_neg ? -op_a : op_a;
  assign b_mag     = b_neg ? -op_b : op_b;

  // Sign-corrected results presented during FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
  assign quo_fix  = neg_res_reg ? -q_reg : q_reg;
  assign rem_fix  = neg_rem_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];

  // Single-iteration datapath.
  logic [2*WIDTH-1:0] acc_step, opnd_step;
  logic [WIDTH-1:0]   q_step;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_reg),
    .acc       (acc_reg),
    .q         (q_reg),
    .opnd      (opnd_reg),
    .acc_next  (acc_step),
    .q_next    (q_step),
    .opnd_next (opnd_step)
  );

  // Once the multiplier shift register is empty, further iterations would
  // add nothing, so the accumulator already holds the final product.
  logic early_out;
`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = !is_div_reg && (q_reg == '0);
`else
  assign early_out = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    acc_next      = acc_reg;
    q_next        = q_reg;
    opnd_next     = opnd_reg;
    is_div_next   = is_div_reg;
    neg_res_next  = neg_res_reg;
    neg_rem_next  = neg_rem_reg;
    div_zero_next = div_zero_reg;
    a_raw_next    = a_raw_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    done_next     = 1'b0;

    case (state_reg)
      MD_IDLE: begin
        if (start) begin
          if (is_iterative(fncode)) begin
            is_div_next   = op_div;
            neg_res_next  = a_neg ^ b_neg;
            neg_rem_next  = a_neg;
            div_zero_next = op_div && (op_b == '0);
            a_raw_next    = op_a;
            acc_next      = '0;
            count_next    = '0;
            if (op_div) begin
              q_next    = a_mag;
              opnd_next = {{WIDTH{1'b0}}, b_mag};
            end else begin
              q_next    = b_mag;
              opnd_next = {{WIDTH{1'b0}}, a_mag};
            end
            state_next = MD_RUN;
          end else if (fncode == FUNCT_MTHI) begin
            hi_next   = op_a;
            done_next = 1'b1;
          end else if (fncode == FUNCT_MTLO) begin
            lo_next   = op_a;
            done_next = 1'b1;
          end
        end
      end

      MD_RUN: begin
        if (early_out) begin
          state_next = MD_FIX;
        end else begin
          acc_next   = acc_step;
          q_next     = q_step;
          opnd_next  = opnd_step;
          count_next = count_reg + 1'b1;
          if (count_reg == CNT_W'(WIDTH - 1)) begin
            state_next = MD_FIX;
          end
        end
      end

      MD_FIX: begin
        if (!is_div_reg) begin
          hi_next = prod_fix[2*WIDTH-1:WIDTH];
          lo_next = prod_fix[WIDTH-1:0];
        end else if (div_zero_reg) begin
          hi_next = a_raw_reg;
          lo_next = '1;
        end else begin
          hi_next = rem_fix;
          lo_next = quo_fix;
        end
        done_next  = 1'b1;
        state_next = MD_IDLE;
      end

      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= MD_IDLE;
      count_reg    <= '0;
      acc_reg      <= '0;
      q_reg        <= '0;
      opnd_reg     <= '0;
      is_div_reg   <= 1'b0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      a_raw_reg    <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      acc_reg      <= acc_next;
      q_reg        <= q_next;
      opnd_reg     <= opnd_next;
      is_div_reg   <= is_div_next;
      neg_res_reg  <= neg_res_next;
      neg_rem_reg  <= neg_rem_next;
      div_zero_reg <= div_zero_next;
      a_raw_reg    <= a_raw_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      done_reg     <= done_next;
    end
  end

  assign busy = (state_reg != MD_IDLE);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Self-checking bench for muldiv_ctrl. Expected HI/LO values come from plain
// 64-bit arithmetic; expected latency comes from the cycle rules (34 cycles,
// or the early-out count when MULDIV_EARLY_OUT_EN is defined). Directed cases
// cover the corner results, then a randomized mix of operations follows.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   fncode = '0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .fncode  (fncode),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Architectural HI/LO as the model sees them.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // {hi, lo} produced by an arithmetic op.
  function automatic logic [63:0] model_res(input logic [5:0] fn, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (fn)
      FUNCT_MULTU: r = {32'b0, a} * {32'b0, b};
      FUNCT_MULT:  r = sa * sb;
      FUNCT_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      FUNCT_DIV: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else begin
          longint qq, rr;
          qq = sa / sb;
          rr = sa % sb;
          r  = {rr[31:0], qq[31:0]};
        end
      end
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  // Cycle (counted from the start cycle = 0) in which done is expected.
  function automatic int model_lat(input logic [5:0] fn, input logic [W-1:0] b);
    int lat;
    lat = 34;
`ifdef MULDIV_EARLY_OUT_EN
    if (fn == FUNCT_MULT || fn == FUNCT_MULTU) begin
      logic [W-1:0] mag;
      int bits;
      mag  = (fn == FUNCT_MULT && b[W-1]) ? -b : b;
      bits = 0;
      for (int i = 0; i < W; i++) if (mag[i]) bits = i + 1;
      lat = (bits + 3 < 34) ? bits + 3 : 34;
    end
`endif
    return lat;
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 255));
      default: return W'($urandom);
    endcase
  endfunction

  // Issue one arithmetic op and follow it to its done pulse.
  task automatic run_op(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit inject);
    logic [63:0] exp;
    int exp_lat, n, busy_cnt, done_cyc;
    bit stable;
    exp     = model_res(fn, a, b);
    exp_lat = model_lat(fn, b);
    @(posedge clk); #1;
    start = 1'b1; fncode = fn; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
    n = 1; busy_cnt = 0; done_cyc = 0; stable = 1'b1;
    while (done_cyc == 0 && n <= 60) begin
      if (done) done_cyc = n;
      else begin
        if (busy) busy_cnt++;
        if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
        if (inject && n == 5) begin
          start = 1'b1; fncode = FUNCT_DIVU; op_a = W'($urandom); op_b = W'($urandom_range(1, 9));
        end
        if (inject && n == 6) start = 1'b0;
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    $display("%s fn=%02h a=%08h b=%08h -> hi=%08h lo=%08h done@%0d", tag, fn, a, b, hi, lo, done_cyc);
    check_val({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_lat));
    check_val({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check_val({tag, " busy@done"}, 64'(busy), 64'd0);
    check_val({tag, " hilo_stable"}, 64'(stable), 64'd1);
    check_val({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    check_val({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(posedge clk); #1;
    check_val({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  task automatic run_mt(input string tag, input logic [5:0] fn, input logic [W-1:0] v);
    @(posedge clk); #1;
    start = 1'b1; fncode = fn; op_a = v;
    @(posedge clk); #1;
    start = 1'b0;
    if (fn == FUNCT_MTHI) m_hi = v; else m_lo = v;
    $display("%s fn=%02h v=%08h -> hi=%08h lo=%08h done=%0b", tag, fn, v, hi, lo, done);
    check_val({tag, " done"}, 64'(done), 64'd1);
    check_val({tag, " busy"}, 64'(busy), 64'd0);
    check_val({tag, " hi"}, 64'(hi), 64'(m_hi));
    check_val({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [5:0] fn_tab [4];
    bit saw_done;
    fn_tab[0] = FUNCT_MULT; fn_tab[1] = FUNCT_MULTU; fn_tab[2] = FUNCT_DIV; fn_tab[3] = FUNCT_DIVU;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst busy", 64'(busy), 64'd0);
    check_val("rst done", 64'(done), 64'd0);
    check_val("rst hi", 64'(hi), 64'd0);
    check_val("rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed arithmetic corners.
    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("div_by0", FUNCT_DIV, 32'h1234, 32'd0, 1'b0);
    run_op("divu_by0", FUNCT_DIVU, 32'h8765_4321, 32'd0, 1'b0);
    run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("multu_5x0", FUNCT_MULTU, 32'd5, 32'd0, 1'b0);
    run_op("multu_5x1", FUNCT_MULTU, 32'd5, 32'd1, 1'b0);
    run_op("mult_negb", FUNCT_MULT, 32'd9, 32'hFFFF_FFFE, 1'b0);

    // MTHI / MTLO, single and back-to-back.
    run_mt("mthi", FUNCT_MTHI, 32'h0000_ABCD);
    run_mt("mtlo", FUNCT_MTLO, 32'h1357_9BDF);
    @(posedge clk); #1;
    start = 1'b1; fncode = FUNCT_MTHI; op_a = 32'hCAFE_0001;
    @(posedge clk); #1;
    fncode = FUNCT_MTLO; op_a = 32'hCAFE_0002;
    m_hi = 32'hCAFE_0001;
    check_val("b2b done1", 64'(done), 64'd1);
    check_val("b2b hi", 64'(hi), 64'(m_hi));
    @(posedge clk); #1;
    start = 1'b0;
    m_lo = 32'hCAFE_0002;
    $display("b2b mthi/mtlo -> hi=%08h lo=%08h done=%0b", hi, lo, done);
    check_val("b2b done2", 64'(done), 64'd1);
    check_val("b2b lo", 64'(lo), 64'(m_lo));
    @(posedge clk); #1;
    check_val("b2b done_end", 64'(done), 64'd0);

    // Unknown funct is ignored.
    start = 1'b1; fncode = 6'h20; op_a = 32'h1111_1111;
    @(posedge clk); #1;
    start = 1'b0;
    $display("ignored fn=20 -> busy=%0b done=%0b hi=%08h lo=%08h", busy, done, hi, lo);
    check_val("ign busy", 64'(busy), 64'd0);
    check_val("ign done", 64'(done), 64'd0);
    check_val("ign hilo", {hi, lo}, {m_hi, m_lo});

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; fncode = FUNCT_DIV; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    $display("mid-op reset -> busy=%0b done=%0b hi=%08h lo=%08h", busy, done, hi, lo);
    check_val("abort busy", 64'(busy), 64'd0);
    check_val("abort hi", 64'(hi), 64'd0);
    check_val("abort lo", 64'(lo), 64'd0);
    check_val("abort done", 64'(done), 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check_val("abort no_done", 64'(saw_done), 64'd0);
    run_op("after_rst", FUNCT_DIVU, 32'd1000, 32'd3, 1'b0);

    // Randomized mix.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0)
        run_mt("rnd_mt", ($urandom_range(0, 1) != 0) ? FUNCT_MTHI : FUNCT_MTLO, W'($urandom));
      else
        run_op("rnd", fn_tab[$urandom_range(0, 3)], rand_opnd(), rand_opnd(), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
